// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined data-memory arbiter.
package pipe_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAccA = 3'd1,
    StAccB = 3'd2,
    StRspA = 3'd3,
    StRspB = 3'd4
  } state_e;

  // Identifies a requester; also the encoding of the last_grant register.
  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_e;

  // Upper address bits of the memory-mapped IO page; writes there never reach the RAM.
  localparam logic [23:0] IO_PAGE = 24'hffffff;

  // True when an address falls in the IO page.
  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[31:8] == IO_PAGE;
  endfunction

endpackage

// File: rtl/pipe_rr_arb2.sv
// Two-way round-robin selector with its last_grant register.
module pipe_rr_arb2
  import pipe_pkg::*;
(
  input  logic ram_clock,
  input  logic resetn,
  input  logic req_a,
  input  logic req_b,
  input  logic upd_en,
  input  port_e upd_port,
  output logic grant_a,
  output logic grant_b,
  output port_e last_grant
);

  port_e last_grant_q;

  // A wins when alone, or on a tie when B was the last port served.
  always_comb begin
    grant_a = req_a & (~req_b | (last_grant_q == PortB));
    grant_b = req_b & ~grant_a;
  end

  // last_grant starts at B so that A wins the first tie after reset.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= PortB;
    end else if (upd_en) begin
      last_grant_q <= upd_port;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/pipe_dmem_arbiter.sv
// Arbitrates two masters onto one synchronous-read data memory.
// Each access takes two cycles: ACC (address/write out, ack) then RSP (read data back).
module pipe_dmem_arbiter
  import pipe_pkg::*;
(
  input  logic        ram_clock,
  input  logic        resetn,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [31:0] addr_a,
  input  logic [31:0] wdata_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  input  logic [31:0] mem_dataout,
  output logic        busy
);

  state_e state_q, state_d;

  logic [31:0] cap_addr_q;
  logic [31:0] cap_wdata_q;
  logic        cap_we_q;

  logic [31:0] rdata_a_q, rdata_b_q;
  logic        rvalid_a_q, rvalid_b_q;

  logic  arb_point;
  logic  grant_a, grant_b;
  logic  in_acc;
  port_e acc_port;
  port_e last_grant;

  // Arbitration happens only in IDLE and RSP; req inputs are masked during ACC.
  always_comb begin
    arb_point = (state_q == StIdle) || (state_q == StRspA) || (state_q == StRspB);
    in_acc    = (state_q == StAccA) || (state_q == StAccB);
    acc_port  = (state_q == StAccB) ? PortB : PortA;
  end

  pipe_rr_arb2 u_arb (
    .ram_clock  (ram_clock),
    .resetn     (resetn),
    .req_a      (req_a & arb_point),
    .req_b      (req_b & arb_point),
    .upd_en     (in_acc),
    .upd_port   (acc_port),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .last_grant (last_grant)
  );

  // Next-state logic: ACC always lasts one cycle, RSP doubles as an arbitration slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRspA, StRspB: begin
        if (grant_a) begin
          state_d = StAccA;
        end else if (grant_b) begin
          state_d = StAccB;
        end else begin
          state_d = StIdle;
        end
      end
      StAccA:  state_d = StRspA;
      StAccB:  state_d = StRspB;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning request on entry to ACC; held afterwards so the memory bus stays stable.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      cap_addr_q  <= 32'h0;
      cap_wdata_q <= 32'h0;
      cap_we_q    <= 1'b0;
    end else if (arb_point && grant_a) begin
      cap_addr_q  <= addr_a;
      cap_wdata_q <= wdata_a;
      cap_we_q    <= we_a;
    end else if (arb_point && grant_b) begin
      cap_addr_q  <= addr_b;
      cap_wdata_q <= wdata_b;
      cap_we_q    <= we_b;
    end
  end

  // Read return: memory data is valid during RSP and is registered, giving rvalid the next cycle.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      rdata_a_q  <= 32'h0;
      rdata_b_q  <= 32'h0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rvalid_a_q <= (state_q == StRspA) && !cap_we_q;
      rvalid_b_q <= (state_q == StRspB) && !cap_we_q;
      if ((state_q == StRspA) && !cap_we_q) begin
        rdata_a_q <= mem_dataout;
      end
      if ((state_q == StRspB) && !cap_we_q) begin
        rdata_b_q <= mem_dataout;
      end
    end
  end

  // Outputs decoded from state so that reset drops ack/mem_we immediately.
  always_comb begin
    ack_a      = (state_q == StAccA);
    ack_b      = (state_q == StAccB);
    mem_we     = in_acc && cap_we_q && !is_io_addr(cap_addr_q);
    mem_addr   = cap_addr_q;
    mem_datain = cap_wdata_q;
    busy       = (state_q != StIdle);
    rvalid_a   = rvalid_a_q;
    rvalid_b   = rvalid_b_q;
    rdata_a    = rdata_a_q;
    rdata_b    = rdata_b_q;
  end

  // last_grant is consumed inside the arbiter; exposed only for debug visibility.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

endmodule

// File: tb/tb_pipe_dmem_arbiter.sv
// Scoreboard bench for pipe_dmem_arbiter with a behavioural synchronous-read RAM.
module tb_pipe_dmem_arbiter;

  logic        ram_clock = 1'b0;
  logic        resetn;
  logic        req_a, we_a, req_b, we_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic        ack_a, ack_b, rvalid_a, rvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic        mem_we, busy;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  int          grant_log[$];
  int          ack_cyc[$];
  logic [31:0] mem[0:255];
  logic [31:0] model_mem[0:255];
  int          cyc = 0;
  int          we_cnt = 0;
  int          n_total = 0;
  int          n_bad = 0;

  pipe_dmem_arbiter dut (
    .ram_clock   (ram_clock),
    .resetn      (resetn),
    .req_a       (req_a),
    .we_a        (we_a),
    .addr_a      (addr_a),
    .wdata_a     (wdata_a),
    .req_b       (req_b),
    .we_b        (we_b),
    .addr_b      (addr_b),
    .wdata_b     (wdata_b),
    .ack_a       (ack_a),
    .ack_b       (ack_b),
    .rvalid_a    (rvalid_a),
    .rvalid_b    (rvalid_b),
    .rdata_a     (rdata_a),
    .rdata_b     (rdata_b),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_we      (mem_we),
    .mem_dataout (mem_dataout),
    .busy        (busy)
  );

  always #5 ram_clock = ~ram_clock;

  always @(posedge ram_clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hCAFEF00D;
    return 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  // Synchronous-read RAM; contents reload while reset is low.
  always @(posedge ram_clock) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_datain;
    end
    mem_dataout <= mem[mem_addr[9:2]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops read expectations, logs grants, polices exclusivity and mem_we.
  always @(negedge ram_clock) begin
    exp_t e;
    if (resetn) begin
      if (ack_a || ack_b) check_val("ack_onehot", {31'h0, ack_a & ack_b}, 32'h0);
      if (rvalid_a || rvalid_b) check_val("rvalid_onehot", {31'h0, rvalid_a & rvalid_b}, 32'h0);
      if (!ack_a && !ack_b) check_val("mem_we_idle", {31'h0, mem_we}, 32'h0);
      if (mem_we) we_cnt++;
      if (ack_a) begin grant_log.push_back(0); ack_cyc.push_back(cyc); end
      if (ack_b) begin grant_log.push_back(1); ack_cyc.push_back(cyc); end
      if (rvalid_a) begin
        if (exp_a.size() == 0) check_val("rvalid_a_unexpected", 32'h1, 32'h0);
        else begin
          e = exp_a.pop_front();
          check_val("rdata_a", rdata_a, e.data);
          check_val("rvalid_a_cycle", cyc, e.cyc);
        end
      end
      if (rvalid_b) begin
        if (exp_b.size() == 0) check_val("rvalid_b_unexpected", 32'h1, 32'h0);
        else begin
          e = exp_b.pop_front();
          check_val("rdata_b", rdata_b, e.data);
          check_val("rvalid_b_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Issue one request, wait (bounded) for its ack, then record expectations.
  task automatic do_req(input bit pb, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, output int waited);
    bit   got;
    exp_t e;
    if (!pb) begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = data; end
    else     begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = data; end
    got    = 1'b0;
    waited = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge ram_clock);
      if (pb ? ack_b : ack_a) begin got = 1'b1; waited = i; end
    end
    if (!got) begin
      check_val(pb ? "ack_b_timeout" : "ack_a_timeout", 32'h0, 32'h1);
    end else begin
      check_val("mem_addr", mem_addr, addr);
      if (we) begin
        check_val("mem_datain", mem_datain, data);
        if (addr[31:8] != 24'hffffff) model_mem[addr[9:2]] = data;
      end else begin
        e.data = model_mem[addr[9:2]];
        e.cyc  = cyc + 2;
        if (!pb) exp_a.push_back(e); else exp_b.push_back(e);
      end
    end
  endtask

  task automatic release_port(input bit pb);
    @(posedge ram_clock);
    #1;
    if (!pb) req_a = 1'b0; else req_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c0;
    bit got;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    resetn = 1'b0;
    repeat (3) @(negedge ram_clock);
    check_val("rst_ack", {30'h0, ack_a, ack_b}, 32'h0);
    check_val("rst_rvalid", {30'h0, rvalid_a, rvalid_b}, 32'h0);
    check_val("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_rdata_a", rdata_a, 32'h0);
    check_val("rst_rdata_b", rdata_b, 32'h0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    resetn = 1'b1;
    @(negedge ram_clock);

    // Single read from port A.
    do_req(0, 0, 32'h0000_0010, 32'h0, w);
    check_val("read_ack_latency", w, 1);
    release_port(0);
    repeat (4) @(negedge ram_clock);
    check_val("read_drained", exp_a.size(), 0);
    check_val("read_rdata_held", rdata_a, 32'hCAFEF00D);
    check_val("idle_busy", {31'h0, busy}, 32'h0);

    // IO-page write from B: acked, never written, no read data.
    c0 = we_cnt;
    do_req(1, 1, 32'hffff_ff20, 32'hDEAD_BEEF, w);
    release_port(1);
    repeat (4) @(negedge ram_clock);
    check_val("io_write_mem_we", we_cnt - c0, 0);

    // Both held continuously: A,B,A,B at two-cycle spacing.
    grant_log.delete();
    ack_cyc.delete();
    fork
      begin
        do_req(0, 0, 32'h0000_0004, 32'h0, w);
        do_req(0, 0, 32'h0000_000C, 32'h0, w);
        release_port(0);
      end
      begin
        do_req(1, 0, 32'h0000_0014, 32'h0, w);
        do_req(1, 0, 32'h0000_0018, 32'h0, w);
        release_port(1);
      end
    join
    repeat (4) @(negedge ram_clock);
    check_val("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check_val("rr_order", grant_log[i], i % 2);
      if (i > 0) check_val("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 2);
    end

    // B writes, A reads back the same word.
    c0 = we_cnt;
    do_req(1, 1, 32'h0000_0008, 32'h1234_5678, w);
    release_port(1);
    repeat (3) @(negedge ram_clock);
    check_val("write_mem_we_cycles", we_cnt - c0, 1);
    do_req(0, 0, 32'h0000_0008, 32'h0, w);
    release_port(0);
    repeat (4) @(negedge ram_clock);
    check_val("write_readback", rdata_a, 32'h1234_5678);

    // Reset during ACC_A (last grant was A, so only reset can make A win the next tie).
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h0000_0014;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge ram_clock);
      if (ack_a) got = 1'b1;
    end
    check_val("abort_reached_acc", {31'h0, got}, 32'h1);
    resetn = 1'b0;
    #1;
    check_val("abort_ack_a", {31'h0, ack_a}, 32'h0);
    check_val("abort_mem_we", {31'h0, mem_we}, 32'h0);
    check_val("abort_busy", {31'h0, busy}, 32'h0);
    check_val("abort_rdata_a", rdata_a, 32'h0);
    req_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ram_clock);
      check_val("abort_rvalid_a", {31'h0, rvalid_a}, 32'h0);
    end
    resetn = 1'b1;
    repeat (3) @(negedge ram_clock);
    grant_log.delete();
    ack_cyc.delete();
    fork
      begin do_req(0, 0, 32'h0000_0014, 32'h0, w); release_port(0); end
      begin do_req(1, 0, 32'h0000_0018, 32'h0, w); release_port(1); end
    join
    repeat (4) @(negedge ram_clock);
    check_val("post_reset_tie_count", grant_log.size(), 2);
    if (grant_log.size() > 0) check_val("post_reset_tie_winner", grant_log[0], 0);

    check_val("final_exp_a_empty", exp_a.size(), 0);
    check_val("final_exp_b_empty", exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
